// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to replace the one-entry holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              parity_sel,
  input  logic              stop_sel,
  input  logic [11:0]       baud_divisor,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  if (DATA_W != 8) begin : g_bad_width
    $error("uart_tx supports DATA_W=8 only");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx FIFO_DEPTH must be a power of 2 and at least 2");
  end

  state_t            state, state_d;
  logic [11:0]       cnt, cnt_d, div_l, div_d;
  logic [2:0]        bit_cnt, bit_d;
  logic              stop_cnt, stop_cnt_d, stop_l, stop_l_d;
  logic              par_bit, par_d, tx_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic              hold_full, launch, push, tick;
  logic [DATA_W-1:0] hold_data;

  assign push = valid_in && ready_out;

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;

  assign ready_out = (count != FULL_CNT);
  assign hold_full = (count != '0);
  assign hold_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [DATA_W-1:0] hold_r;
  logic              hold_full_r;

  assign ready_out = !hold_full_r;
  assign hold_full = hold_full_r;
  assign hold_data = hold_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r      <= '0;
      hold_full_r <= 1'b0;
    end else begin
      if (push) hold_r <= data_in;
      hold_full_r <= (hold_full_r && !launch) || push;
    end
  end
`endif

  assign busy = (state != IDLE);
  assign tick = busy && (cnt == div_l - 12'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_l    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      stop_l   <= 1'b0;
      par_bit  <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      div_l    <= div_d;
      bit_cnt  <= bit_d;
      stop_cnt <= stop_cnt_d;
      stop_l   <= stop_l_d;
      par_bit  <= par_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

  // tx is registered from the next-state value so it changes on the same edge as the state.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    div_d      = div_l;
    bit_d      = bit_cnt;
    stop_cnt_d = stop_cnt;
    stop_l_d   = stop_l;
    par_d      = par_bit;
    shift_d    = shift;
    tx_d       = tx;
    done       = 1'b0;
    launch     = 1'b0;

    if (busy) cnt_d = tick ? 12'd0 : cnt + 12'd1;

    case (state)
      IDLE: launch = hold_full && tx_en;
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            shift_d = shift >> 1;
            bit_d   = bit_cnt + 3'd1;
            tx_d    = shift[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == stop_l) begin
            done    = 1'b1;
            state_d = IDLE;
            launch  = hold_full && tx_en;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d  = START;
      cnt_d    = 12'd0;
      tx_d     = 1'b0;
      shift_d  = hold_data;
      par_d    = parity_sel ? ^hold_data : ~^hold_data;
      div_d    = (baud_divisor == 12'd0) ? 12'd1 : baud_divisor;
      stop_l_d = stop_sel;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shape, back-to-back, tx_en gating,
// reset mid-frame, divisor corner cases, and the FIFO build when UART_TX_FIFO_EN is defined.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic        parity_sel = 1'b1;
  logic        stop_sel = 1'b0;
  logic [11:0] baud_divisor = 12'd4;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        ready_out, tx, busy, done;

  int total = 0;
  int bad = 0;

  uart_tx dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .parity_sel(parity_sel),
    .stop_sel(stop_sel), .baud_divisor(baud_divisor), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_out), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setConfig(input logic [11:0] div, input logic two_stop, input logic even, input logic en);
    baud_divisor = div;
    stop_sel     = two_stop;
    parity_sel   = even;
    tx_en        = en;
  endtask

  // Presents one byte for a single edge; caller guarantees ready_out is high.
  task automatic applyStimulus(input logic [7:0] d);
    data_in  = d;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  // Starts one clock before the frame's first tx=0 cycle and ends on its last stop clock.
  task automatic checkFrame(input logic [7:0] d, input int div, input logic two_stop, input logic par);
    logic [11:0] bits;
    int len;
    len  = (11 + int'(two_stop)) * div;
    bits = {1'b1, 1'b1, par, d, 1'b0};
    for (int c = 1; c <= len; c++) begin
      step();
      checkOutput("frame_tx", {31'd0, tx}, {31'd0, bits[(c - 1) / div]});
      checkOutput("frame_busy", {31'd0, busy}, 32'd1);
      checkOutput("frame_done", {31'd0, done}, (c == len) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_tx"}, {31'd0, tx}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    checkIdle("reset");
    checkOutput("reset_ready", {31'd0, ready_out}, 32'd1);
    step();
    reset = 1'b1;
    step();

    $display("[TB] basic frame 0xA5, div 4, even parity, one stop");
    setConfig(12'd4, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'hA5);
    checkOutput("basic_ready_held", {31'd0, ready_out}, 32'd0);
    checkFrame(8'hA5, 4, 1'b0, 1'b0);
    step();
    checkIdle("basic_after");
    checkOutput("basic_ready_after", {31'd0, ready_out}, 32'd1);

    $display("[TB] odd parity, two stop bits, 0x01, div 3");
    setConfig(12'd3, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h01);
    checkFrame(8'h01, 3, 1'b1, 1'b0);
    step();
    checkIdle("odd_after");

    $display("[TB] back-to-back 0x55 then 0xAA, div 2");
    setConfig(12'd2, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h55);
    fork
      checkFrame(8'h55, 2, 1'b0, 1'b0);
      begin
        data_in  = 8'hAA;
        valid_in = 1'b1;
        step();
        step();
        valid_in = 1'b0;
        for (int c = 2; c <= 22; c++) begin
          checkOutput("b2b_ready_low", {31'd0, ready_out}, 32'd0);
          if (c < 22) step();
        end
      end
    join
    checkFrame(8'hAA, 2, 1'b0, 1'b0);
    checkOutput("b2b_ready_after", {31'd0, ready_out}, 32'd1);
    step();
    checkIdle("b2b_after");

    $display("[TB] tx_en gating with 0x3C");
    setConfig(12'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h3C);
    for (int c = 0; c < 5; c++) begin
      checkOutput("gate_tx", {31'd0, tx}, 32'd1);
      checkOutput("gate_ready", {31'd0, ready_out}, 32'd0);
      checkOutput("gate_busy", {31'd0, busy}, 32'd0);
      step();
    end
    tx_en = 1'b1;
    checkFrame(8'h3C, 2, 1'b0, 1'b0);
    step();
    checkIdle("gate_after");

    $display("[TB] reset during data bit 3 of 0xF7");
    setConfig(12'd4, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'hF7);
    repeat (18) step();
    checkOutput("rst_mid_tx_before", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    checkIdle("rst_mid");
    checkOutput("rst_mid_ready", {31'd0, ready_out}, 32'd1);
    step();
    reset = 1'b1;
    step();
    applyStimulus(8'h5A);
    checkFrame(8'h5A, 4, 1'b0, 1'b0);
    step();
    checkIdle("rst_next_after");

    $display("[TB] divisor 0 behaves as 1, 0xC3");
    setConfig(12'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'hC3);
    checkFrame(8'hC3, 1, 1'b0, 1'b0);
    step();
    checkIdle("div0_after");

    $display("[TB] config change mid-frame, 0x81 at div 3");
    setConfig(12'd3, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h81);
    fork
      checkFrame(8'h81, 3, 1'b0, 1'b0);
      begin
        repeat (5) step();
        setConfig(12'd7, 1'b1, 1'b0, 1'b1);
        data_in = 8'hFF;
      end
    join
    step();
    checkIdle("midchg_after");

`ifdef UART_TX_FIFO_EN
    $display("[TB] FIFO: four bytes queued then sent contiguously");
    setConfig(12'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    checkOutput("fifo_ready_3", {31'd0, ready_out}, 32'd1);
    applyStimulus(8'h44);
    checkOutput("fifo_ready_4", {31'd0, ready_out}, 32'd0);
    tx_en = 1'b1;
    checkFrame(8'h11, 2, 1'b0, 1'b1);
    checkFrame(8'h22, 2, 1'b0, 1'b1);
    checkFrame(8'h33, 2, 1'b0, 1'b1);
    checkFrame(8'h44, 2, 1'b0, 1'b1);
    step();
    checkIdle("fifo_after");
    checkOutput("fifo_ready_after", {31'd0, ready_out}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
